// File: rtl/demux_nx1x2_stream.sv
// Registered 1-to-2 valid/ready stream demultiplexer with an independent FIFO per output lane.
// Optional per-lane pop counters are enabled by defining DEMUX_STATS_EN.
module demux_nx1x2_stream #(
   parameter int unsigned DATA_LENGTH = 64,
   parameter int unsigned FIFO_DEPTH  = 2,
   parameter int unsigned COUNT_WIDTH = 16
) (
   input  logic                        clk_i,
   input  logic                        reset_n_i,
   input  logic                        in_valid_i,
   output logic                        in_ready_o,
   input  logic [DATA_LENGTH-1:0]      in_data_i,
   input  logic                        select_i,
   output logic [1:0]                  out_valid_o,
   input  logic [1:0]                  out_ready_i,
   output logic [1:0][DATA_LENGTH-1:0] out_data_o
`ifdef DEMUX_STATS_EN
   ,
   output logic [1:0][COUNT_WIDTH-1:0] stat_count_o
`endif
);

   localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

   logic [1:0][CNT_W-1:0]  count_q,  count_d;
   logic [1:0][PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [1:0][PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [DATA_LENGTH-1:0] mem_q [2][FIFO_DEPTH];
   logic [DATA_LENGTH-1:0] mem_d [2][FIFO_DEPTH];

   logic [1:0] full;
   logic [1:0] lane_sel;
   logic [1:0] push;
   logic [1:0] pop;

   always_comb begin
      full        = '0;
      out_valid_o = '0;
      out_data_o  = '0;
      for (int unsigned k = 0; k < 2; k++) begin
         full[k]        = (count_q[k] == FULL_CNT);
         out_valid_o[k] = (count_q[k] != '0);
         out_data_o[k]  = mem_q[k][rd_ptr_q[k]];
      end
   end

   // A full lane refuses the beat even if it pops in the same cycle: no pass-through.
   assign in_ready_o = ~full[select_i];
   assign lane_sel   = {select_i, ~select_i};
   assign push       = lane_sel & {2{in_valid_i & in_ready_o}};
   assign pop        = out_valid_o & out_ready_i;

   always_comb begin
      count_d  = count_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      mem_d    = mem_q;
      for (int unsigned k = 0; k < 2; k++) begin
         if (push[k]) begin
            mem_d[k][wr_ptr_q[k]] = in_data_i;
            wr_ptr_d[k]           = wr_ptr_q[k] + PTR_W'(1);
         end
         if (pop[k]) begin
            rd_ptr_d[k] = rd_ptr_q[k] + PTR_W'(1);
         end
         count_d[k] = count_q[k] + CNT_W'(push[k]) - CNT_W'(pop[k]);
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         count_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         mem_q    <= '{default: '0};
      end else begin
         count_q  <= count_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         mem_q    <= mem_d;
      end
   end

`ifdef DEMUX_STATS_EN
   logic [1:0][COUNT_WIDTH-1:0] stat_q, stat_d;

   // Saturating pop counters; they hold at all-ones rather than wrapping.
   always_comb begin
      stat_d = stat_q;
      for (int unsigned k = 0; k < 2; k++) begin
         if (pop[k] && (stat_q[k] != '1)) begin
            stat_d[k] = stat_q[k] + COUNT_WIDTH'(1);
         end
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         stat_q <= '0;
      end else begin
         stat_q <= stat_d;
      end
   end

   assign stat_count_o = stat_q;
`endif

endmodule
